// File: rtl/arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arbiter_pkg
//  Purpose  : Shared constants and helper functions for the weighted
//             round-robin arbiter (mode encodings, one-hot to binary,
//             single-step rotations within a given active width).
//  Revision : 1.0  initial release
// ============================================================================
package arbiter_pkg;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    // Helpers work on a fixed container width; callers cast in and out.
    localparam int MAX_PORTS     = 32;
    localparam int MAX_SEL_WIDTH = 5;

    // Binary index of the set bit of a one-hot vector; 0 for an all-zero vector.
    function automatic logic [MAX_SEL_WIDTH-1:0] onehot_to_bin(input logic [MAX_PORTS-1:0] vec);
        logic [MAX_SEL_WIDTH-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (vec[i]) begin
                idx = idx | MAX_SEL_WIDTH'(i);
            end
        end
        return idx;
    endfunction

    // Rotate the low 'width' bits left by one position (bit width-1 wraps to bit 0).
    function automatic logic [MAX_PORTS-1:0] rotl1(input logic [MAX_PORTS-1:0] vec, input int width);
        logic [MAX_PORTS-1:0] res;
        res = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (i < width) begin
                res[(i + 1) % width] = vec[i];
            end
        end
        return res;
    endfunction

    // Rotate the low 'width' bits right by one position (bit 0 wraps to bit width-1).
    function automatic logic [MAX_PORTS-1:0] rotr1(input logic [MAX_PORTS-1:0] vec, input int width);
        logic [MAX_PORTS-1:0] res;
        res = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (i < width) begin
                res[(i + width - 1) % width] = vec[i];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wrr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational circular first-one search. Returns the first
//             requester at or after the one-hot start position, wrapping
//             around to the bits below it.
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] req,
    input  logic [WIDTH-1:0] start_onehot,
    output logic [WIDTH-1:0] winner_onehot
);

    logic [WIDTH-1:0]   w_mask;
    logic [2*WIDTH-1:0] w_dbl;
    logic [2*WIDTH-1:0] w_iso;

    // Positions at or above the start bit; an all-zero start masks everything
    // so the search falls through to the unmasked upper copy.
    assign w_mask = ~(start_onehot - WIDTH'(1));

    // Lower copy holds only the in-window requests, upper copy provides the wrap.
    assign w_dbl  = {req, req & w_mask};

    // Isolate the lowest set bit of the doubled vector.
    assign w_iso  = w_dbl & (~w_dbl + (2*WIDTH)'(1));

    // Fold both halves back onto the port positions.
    assign winner_onehot = w_iso[WIDTH-1:0] | w_iso[2*WIDTH-1:WIDTH];

endmodule
`default_nettype wire

// File: rtl/wrr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wrr_arbiter
//  Purpose  : Weighted round-robin arbiter with a fixed-priority mode.
//             A port may hold the grant for up to its weight in consecutive
//             cycles; hand-over is look-ahead so no idle cycle is inserted.
//             grant/select/credit are registered.
//  Revision : 1.0  initial release
// ============================================================================
module wrr_arbiter
    import arbiter_pkg::*;
#(
    parameter  int NUM_PORTS    = 6,
    parameter  int WEIGHT_WIDTH = 4,
    localparam int SEL_WIDTH    = $clog2(NUM_PORTS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_PORTS-1:0]              request,
    input  logic [NUM_PORTS*WEIGHT_WIDTH-1:0] weight,
    input  logic                              mode,
    output logic [NUM_PORTS-1:0]              grant,
    output logic [SEL_WIDTH-1:0]              select,
    output logic                              active,
    output logic [WEIGHT_WIDTH-1:0]           credit
);

    logic [NUM_PORTS-1:0]    r_grant;
    logic [SEL_WIDTH-1:0]    r_select;
    logic [WEIGHT_WIDTH-1:0] r_credit;
    logic [NUM_PORTS-1:0]    r_last_owner;

    logic [NUM_PORTS-1:0]    w_start;
    logic [NUM_PORTS-1:0]    w_pick;
    logic [WEIGHT_WIDTH-1:0] w_pick_weight;
    logic                    w_hold;
    logic [NUM_PORTS-1:0]    w_next_grant;
    logic [WEIGHT_WIDTH-1:0] w_next_credit;
    logic [NUM_PORTS-1:0]    w_next_last;

    // Fixed priority searches from port 0; round-robin from the port after the last owner.
    assign w_start = (mode == MODE_FIXED)
                   ? NUM_PORTS'(1)
                   : NUM_PORTS'(rotl1(MAX_PORTS'(r_last_owner), NUM_PORTS));

    rr_pick #(
        .WIDTH         (NUM_PORTS)
    ) u_rr_pick (
        .req           (request),
        .start_onehot  (w_start),
        .winner_onehot (w_pick)
    );

    // Weight of the search winner, used only when a new burst is loaded.
    always_comb begin
        w_pick_weight = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_pick[p]) begin
                w_pick_weight = w_pick_weight | weight[p*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            end
        end
    end

    // Hold while the current owner keeps requesting and has beats left.
    assign w_hold = (mode == MODE_RR) && (|(r_grant & request)) && (r_credit != '0);

    // Next owner, credit and rotation pointer.
    always_comb begin
        w_next_grant  = w_pick;
        w_next_credit = '0;
        if (mode == MODE_FIXED) begin
            w_next_credit = '0;
        end else if (w_hold) begin
            w_next_grant  = r_grant;
            w_next_credit = r_credit - WEIGHT_WIDTH'(1);
        end else if (w_pick != '0) begin
            // A weight of 0 behaves as 1, leaving no extra beats.
            w_next_credit = (w_pick_weight == '0) ? '0 : (w_pick_weight - WEIGHT_WIDTH'(1));
        end
        w_next_last = (w_next_grant != '0) ? w_next_grant : r_last_owner;
    end

    // Output and state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant      <= '0;
            r_select     <= '0;
            r_credit     <= '0;
            r_last_owner <= NUM_PORTS'(1) << (NUM_PORTS - 1);
        end else begin
            r_grant      <= w_next_grant;
            r_select     <= SEL_WIDTH'(onehot_to_bin(MAX_PORTS'(w_next_grant)));
            r_credit     <= w_next_credit;
            r_last_owner <= w_next_last;
        end
    end

    assign grant  = r_grant;
    assign select = r_select;
    assign active = |r_grant;
    assign credit = r_credit;

endmodule
`default_nettype wire
